// File: rtl/cacheline_adaptor_if.sv
// Cache-line / memory-burst bus bundle between a cache and a burst-oriented memory port.
// slave is the adaptor's view; master is the view of whatever drives the cache and memory sides.
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits cache-line reads/writes into BEATS memory beats; resp_o pulses one cycle after the last beat (>= 5 cycles).
// Memory stalls by holding resp_i low; cache requests are latched on acceptance and ignored until the return to IDLE.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input logic                  clk,
  input logic                  rst,
  cacheline_adaptor_if.slave   bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               last_beat;
  logic [LINE_W-1:0]  wr_line;

  assign cnt_nxt   = cnt + 1'b1;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      wr_line       <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.resp_o    <= 1'b0;
      bus.address_o <= '0;
      bus.burst_o   <= '0;
      bus.line_o    <= '0;
    end else begin
      bus.resp_o <= 1'b0;
      case (state)
        IDLE: begin
          // Read wins when both requests arrive together.
          if (bus.read_i) begin
            state         <= READ;
            bus.read_o    <= 1'b1;
            bus.address_o <= bus.address_i & ALIGN_MASK;
            cnt           <= '0;
          end else if (bus.write_i) begin
            state         <= WRITE;
            bus.write_o   <= 1'b1;
            bus.address_o <= bus.address_i & ALIGN_MASK;
            wr_line       <= bus.line_i;
            bus.burst_o   <= bus.line_i[BURST_W-1:0];
            cnt           <= '0;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            bus.line_o[cnt*BURST_W +: BURST_W] <= bus.burst_i;
            cnt <= cnt_nxt;
            if (last_beat) begin
              state      <= DONE;
              bus.read_o <= 1'b0;
              bus.resp_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            cnt <= cnt_nxt;
            // burst_o keeps the final beat once the line has been sent.
            if (last_beat) begin
              state       <= DONE;
              bus.write_o <= 1'b0;
              bus.resp_o  <= 1'b1;
            end else begin
              bus.burst_o <= wr_line[cnt_nxt*BURST_W +: BURST_W];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: directed scenarios plus randomized reads/writes with random memory wait states,
// checked against a line/beat model built from the request data.
module tb_cacheline_adaptor;
  localparam int LW = 256;
  localparam int BW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if #(.LINE_W(LW), .BURST_W(BW)) bus();
  cacheline_adaptor #(.LINE_W(LW), .BURST_W(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [LW-1:0] last_line;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  task automatic idle_inputs();
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.resp_i = 1'b0;
    bus.address_i = '0; bus.line_i = '0; bus.burst_i = '0;
  endtask

  // Drives one cache read and plays memory; beat k of the line is beats[k*64 +: 64].
  task automatic run_read(input logic [31:0] addr, input logic [LW-1:0] beats, input int wait_pct,
                          input bit also_write, input logic [LW-1:0] prev_line,
                          output int lat, output int rd_cyc, output int resp_n, output int bad_addr,
                          output int wr_seen, output int unstable, output bit to);
    int k; int cyc; int tail; bit done_seen;
    k = 0; cyc = 0; tail = 0; done_seen = 0;
    lat = 0; rd_cyc = 0; resp_n = 0; bad_addr = 0; wr_seen = 0; unstable = 0; to = 0;
    @(negedge clk);
    bus.read_i = 1'b1; bus.write_i = also_write; bus.address_i = addr;
    bus.line_i = rnd_line(); bus.resp_i = 1'b0;
    while (tail < 3) begin
      @(negedge clk);
      cyc++;
      if (cyc > 300) begin to = 1; break; end
      if (!done_seen) begin bus.address_i = $urandom; bus.line_i = rnd_line(); end
      if (bus.read_o) begin rd_cyc++; if (bus.address_o !== align(addr)) bad_addr++; end
      if (bus.write_o) wr_seen++;
      if (k == 0 && bus.line_o !== prev_line) unstable++;
      if (bus.resp_o) begin
        resp_n++;
        if (!done_seen) lat = cyc;
        done_seen = 1; bus.read_i = 1'b0; bus.write_i = 1'b0;
      end
      if (done_seen) tail++;
      if (bus.read_o && k < 4 && $urandom_range(99) >= wait_pct) begin
        bus.resp_i = 1'b1; bus.burst_i = beats[k*64 +: 64]; k++;
      end else begin
        bus.resp_i = 1'b0; bus.burst_i = rnd64();
      end
    end
    bus.resp_i = 1'b0;
  endtask

  // Drives one cache write; toggle=1 gives resp_i 1,0,1,0,... while write_o is high.
  task automatic run_write(input logic [31:0] addr, input logic [LW-1:0] line, input bit toggle,
                           input int wait_pct, input logic [LW-1:0] prev_line,
                           output int wr_cyc, output int resp_n, output int bad_addr, output int bad_beat,
                           output int rd_seen, output int bad_line, output bit to);
    int k; int cyc; int tail; bit done_seen; bit tog; bit r;
    k = 0; cyc = 0; tail = 0; done_seen = 0; tog = 1;
    wr_cyc = 0; resp_n = 0; bad_addr = 0; bad_beat = 0; rd_seen = 0; bad_line = 0; to = 0;
    @(negedge clk);
    bus.write_i = 1'b1; bus.read_i = 1'b0; bus.address_i = addr; bus.line_i = line; bus.resp_i = 1'b0;
    while (tail < 3) begin
      @(negedge clk);
      cyc++;
      if (cyc > 300) begin to = 1; break; end
      if (!done_seen) begin bus.address_i = $urandom; bus.line_i = rnd_line(); end
      if (bus.write_o) begin
        wr_cyc++;
        if (bus.address_o !== align(addr)) bad_addr++;
        if (k < 4 && bus.burst_o !== line[k*64 +: 64]) bad_beat++;
      end
      if (bus.read_o) rd_seen++;
      if (bus.line_o !== prev_line) bad_line++;
      if (bus.resp_o) begin resp_n++; done_seen = 1; bus.write_i = 1'b0; end
      if (done_seen) tail++;
      bus.burst_i = rnd64();
      if (bus.write_o && k < 4) begin
        if (toggle) begin r = tog; tog = ~tog; end
        else r = ($urandom_range(99) >= wait_pct);
        bus.resp_i = r;
        if (r) k++;
      end else begin
        bus.resp_i = 1'b0;
      end
    end
    bus.resp_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL reset_read_o: got %b want 0", bus.read_o); end
    checks++; if (bus.write_o !== 1'b0) begin failures++; $display("FAIL reset_write_o: got %b want 0", bus.write_o); end
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL reset_resp_o: got %b want 0", bus.resp_o); end
    checks++; if (bus.address_o !== 32'h0) begin failures++; $display("FAIL reset_address_o: got %h want 0", bus.address_o); end
    checks++; if (bus.burst_o !== 64'h0) begin failures++; $display("FAIL reset_burst_o: got %h want 0", bus.burst_o); end
    checks++; if (bus.line_o !== '0) begin failures++; $display("FAIL reset_line_o: got %h want 0", bus.line_o); end
    rst = 1'b0;
    last_line = '0;
  endtask

  task automatic test_read_basic();
    logic [LW-1:0] beats;
    int lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable; bit to;
    beats = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    run_read(32'h0000_1234, beats, 0, 0, last_line, lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable, to);
    checks++; if (to) begin failures++; $display("FAIL rd_basic_timeout: got timeout want resp_o"); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL rd_basic_latency: got %0d want 5", lat); end
    checks++; if (rd_cyc !== 4) begin failures++; $display("FAIL rd_basic_read_cycles: got %0d want 4", rd_cyc); end
    checks++; if (resp_n !== 1) begin failures++; $display("FAIL rd_basic_resp_count: got %0d want 1", resp_n); end
    checks++; if (bad_addr !== 0) begin failures++; $display("FAIL rd_basic_addr_during: got %0d bad want 0", bad_addr); end
    checks++; if (bus.address_o !== 32'h0000_1220) begin failures++; $display("FAIL rd_basic_addr_hold: got %h want 00001220", bus.address_o); end
    checks++; if (bus.line_o !== beats) begin failures++; $display("FAIL rd_basic_line: got %h want %h", bus.line_o, beats); end
    checks++; if (unstable !== 0 || wr_seen !== 0) begin failures++; $display("FAIL rd_basic_side: got unstable=%0d write_o=%0d want 0/0", unstable, wr_seen); end
    last_line = beats;
  endtask

  task automatic test_write_toggle();
    logic [LW-1:0] line;
    int wr_cyc, resp_n, bad_addr, bad_beat, rd_seen, bad_line; bit to;
    line = {8{32'hDEADBEEF}};
    run_write(32'h0000_ABCD, line, 1, 0, last_line, wr_cyc, resp_n, bad_addr, bad_beat, rd_seen, bad_line, to);
    checks++; if (to) begin failures++; $display("FAIL wr_tog_timeout: got timeout want resp_o"); end
    checks++; if (wr_cyc !== 7) begin failures++; $display("FAIL wr_tog_write_cycles: got %0d want 7", wr_cyc); end
    checks++; if (bad_beat !== 0) begin failures++; $display("FAIL wr_tog_beats: got %0d bad want 0", bad_beat); end
    checks++; if (resp_n !== 1) begin failures++; $display("FAIL wr_tog_resp_count: got %0d want 1", resp_n); end
    checks++; if (bad_addr !== 0 || bus.address_o !== 32'h0000_ABC0) begin failures++; $display("FAIL wr_tog_addr: got %h bad=%0d want 0000abc0", bus.address_o, bad_addr); end
    checks++; if (bus.burst_o !== line[255:192]) begin failures++; $display("FAIL wr_tog_burst_hold: got %h want %h", bus.burst_o, line[255:192]); end
    checks++; if (rd_seen !== 0 || bad_line !== 0) begin failures++; $display("FAIL wr_tog_side: got read_o=%0d line_changes=%0d want 0/0", rd_seen, bad_line); end
  endtask

  task automatic test_priority();
    logic [LW-1:0] beats;
    int lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable; bit to;
    beats = rnd_line();
    run_read(32'h8000_0040, beats, 0, 1, last_line, lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable, to);
    checks++; if (wr_seen !== 0) begin failures++; $display("FAIL prio_write_o: got %0d cycles want 0", wr_seen); end
    checks++; if (rd_cyc !== 4 || resp_n !== 1 || to) begin failures++; $display("FAIL prio_read: got rd=%0d resp=%0d to=%0d want 4/1/0", rd_cyc, resp_n, to); end
    checks++; if (bus.line_o !== beats) begin failures++; $display("FAIL prio_line: got %h want %h", bus.line_o, beats); end
    last_line = beats;
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] a, b;
    int lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable; bit to;
    a = rnd_line(); b = rnd_line();
    @(negedge clk); bus.read_i = 1'b1; bus.address_i = 32'h0000_2000; bus.resp_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.read_o !== 1'b1) begin failures++; $display("FAIL rstmid_read_start: got %b want 1", bus.read_o); end
    bus.read_i = 1'b0; bus.resp_i = 1'b1; bus.burst_i = a[63:0];
    @(negedge clk); bus.burst_i = a[127:64];
    @(negedge clk); bus.resp_i = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL rstmid_read_o: got %b want 0", bus.read_o); end
    checks++; if (bus.line_o !== '0 || bus.resp_o !== 1'b0) begin failures++; $display("FAIL rstmid_clear: got line=%h resp=%b want 0/0", bus.line_o, bus.resp_o); end
    @(negedge clk);
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL rstmid_no_resp: got %b want 0", bus.resp_o); end
    rst = 1'b0;
    last_line = '0;
    run_read(32'h0000_3F3F, b, 0, 0, last_line, lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable, to);
    checks++; if (rd_cyc !== 4 || resp_n !== 1 || lat !== 5 || to) begin failures++; $display("FAIL rstmid_next_read: got rd=%0d resp=%0d lat=%0d to=%0d want 4/1/5/0", rd_cyc, resp_n, lat, to); end
    checks++; if (bus.line_o !== b) begin failures++; $display("FAIL rstmid_line: got %h want %h", bus.line_o, b); end
    last_line = b;
  endtask

  task automatic test_spurious();
    logic [LW-1:0] beats;
    int lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable; bit to;
    int spur;
    spur = 0;
    beats = rnd_line();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.resp_o || bus.read_o || bus.write_o) spur++;
      bus.resp_i = 1'b1; bus.burst_i = rnd64();
    end
    @(negedge clk); bus.resp_i = 1'b0;
    checks++; if (bus.line_o !== last_line) begin failures++; $display("FAIL spur_line: got %h want %h", bus.line_o, last_line); end
    checks++; if (spur !== 0 || bus.resp_o !== 1'b0) begin failures++; $display("FAIL spur_outputs: got %0d active want 0", spur); end
    run_read(32'h0101_0101, beats, 40, 0, last_line, lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable, to);
    checks++; if (unstable !== 0) begin failures++; $display("FAIL spur_line_stable: got %0d changes want 0", unstable); end
    checks++; if (rd_cyc < 4 || lat !== rd_cyc + 1 || resp_n !== 1 || to) begin failures++; $display("FAIL spur_read: got rd=%0d lat=%0d resp=%0d to=%0d want rd>=4 lat=rd+1 resp=1", rd_cyc, lat, resp_n, to); end
    checks++; if (bus.line_o !== beats) begin failures++; $display("FAIL spur_read_line: got %h want %h", bus.line_o, beats); end
    last_line = beats;
  endtask

  task automatic test_random();
    logic [LW-1:0] d;
    logic [31:0] addr;
    int lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable;
    int wr_cyc, bad_beat, rd_seen, bad_line;
    bit to;
    for (int it = 0; it < 14; it++) begin
      d = rnd_line(); addr = $urandom;
      if ($urandom_range(1) == 0) begin
        run_read(addr, d, $urandom_range(50), 0, last_line, lat, rd_cyc, resp_n, bad_addr, wr_seen, unstable, to);
        checks++;
        if (to || resp_n !== 1 || bus.line_o !== d || bad_addr !== 0 || unstable !== 0 || wr_seen !== 0 || rd_cyc < 4 || lat !== rd_cyc + 1) begin
          failures++;
          $display("FAIL rand_read[%0d]: got to=%0d resp=%0d bad_addr=%0d unstable=%0d wr=%0d rd=%0d lat=%0d line_ok=%0d want 0/1/0/0/0/>=4/rd+1/1",
                   it, to, resp_n, bad_addr, unstable, wr_seen, rd_cyc, lat, bus.line_o === d);
        end
        last_line = d;
      end else begin
        run_write(addr, d, 0, $urandom_range(50), last_line, wr_cyc, resp_n, bad_addr, bad_beat, rd_seen, bad_line, to);
        checks++;
        if (to || resp_n !== 1 || bad_addr !== 0 || bad_beat !== 0 || rd_seen !== 0 || bad_line !== 0 || wr_cyc < 4 || bus.burst_o !== d[255:192]) begin
          failures++;
          $display("FAIL rand_write[%0d]: got to=%0d resp=%0d bad_addr=%0d bad_beat=%0d rd=%0d line_chg=%0d wr=%0d hold_ok=%0d want 0/1/0/0/0/0/>=4/1",
                   it, to, resp_n, bad_addr, bad_beat, rd_seen, bad_line, wr_cyc, bus.burst_o === d[255:192]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_toggle();
    test_priority();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
